gpio_pattern_seq: RTL and testbench

//  Autonomous sequencer for the 8-bit APB GPIO output register. Software loads a pattern table,
//  an interval and a length over an APB-style config port. The block then replays the table onto
//  the GPIO's write port (PSEL/PWRITE/PWDATA) at a fixed cadence, once or in a loop.

---
 rtl/gpio_seq_pkg.sv | 23 ++
 rtl/gpio_seq_timer.sv | 29 ++
 rtl/gpio_pattern_seq.sv | 183 ++++++++++++++++++
 tb/tb_gpio_pattern_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the GPIO pattern sequencer: config register map,
// CTRL bit positions and sequencer state encoding.
package gpio_seq_pkg;

    // Config port byte offsets
    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h04;
    localparam logic [5:0] ADDR_INTERVAL = 6'h08;
    localparam logic [5:0] ADDR_LEN      = 6'h0C;
    localparam logic [5:0] ADDR_PAT_BASE = 6'h20;

    // CTRL register bits
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/gpio_seq_timer.sv
// Interval down-counter: loads a value, counts down to zero while enabled and
// then holds at zero.
module gpio_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement stops at zero
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gpio_pattern_seq.sv
// Autonomous GPIO pattern sequencer. Software fills a pattern table and sets
// interval/length over the config port; the FSM then replays the table onto
// the gpio write port, once or looping, one strobe every INTERVAL+2 cycles.
module gpio_pattern_seq
    import gpio_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PWRITE,
    input  logic [5:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        g_psel,
    output logic        g_pwrite,
    output logic [31:0] g_pwdata,
    output logic        busy,
    output logic        done_pulse
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    seq_state_t       state;
    logic [4:0]       idx;
    logic             loop_q;
    logic [CNT_W-1:0] interval_q;
    logic [4:0]       len_q;
    logic [7:0]       pattern [DEPTH];
    logic             start_q;
    logic             busy_q;
    logic             g_psel_q;
    logic             done_q;

    logic             wr_en;
    logic             wr_ctrl;
    logic             stop_req;
    logic [3:0]       pat_word;
    logic             pat_hit;
    logic [4:0]       len_eff;
    logic             last_entry;
    logic             cnt_zero;
    logic             unused_pwdata;

    assign wr_en    = PSEL && PWRITE;
    assign wr_ctrl  = wr_en && (PADDR == ADDR_CTRL);
    // STOP acts directly on the FSM so it lands on the edge that samples it
    assign stop_req = wr_ctrl && PWDATA[CTRL_STOP];

    assign pat_word = PADDR[5:2] - ADDR_PAT_BASE[5:2];
    assign pat_hit  = (PADDR >= ADDR_PAT_BASE) && (PADDR[1:0] == 2'b00) &&
                      ({1'b0, pat_word} < DEPTH_L);

    assign len_eff    = (len_q > DEPTH_L) ? DEPTH_L : len_q;
    assign last_entry = (({1'b0, idx} + 6'd1) >= {1'b0, len_eff});

    assign unused_pwdata = ^PWDATA[31:CNT_W];

    gpio_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .load     (state == ST_WRITE),
        .load_val (interval_q),
        .en       (state == ST_WAIT),
        .zero     (cnt_zero)
    );

    // Control registers; START is latched for one cycle and only accepted when idle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            start_q    <= 1'b0;
            loop_q     <= 1'b0;
            interval_q <= '0;
            len_q      <= '0;
        end else begin
            start_q <= wr_ctrl && PWDATA[CTRL_START] && !PWDATA[CTRL_STOP] && !busy_q;
            if (wr_ctrl) begin
                loop_q <= PWDATA[CTRL_LOOP];
            end
            if (wr_en && (PADDR == ADDR_INTERVAL) && !busy_q) begin
                interval_q <= PWDATA[CNT_W-1:0];
            end
            if (wr_en && (PADDR == ADDR_LEN) && !busy_q) begin
                len_q <= PWDATA[4:0];
            end
        end
    end

    // Pattern table; writable at any time, a running sequence picks up new values
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr_en && pat_hit) begin
            pattern[pat_word[IDX_W-1:0]] <= PWDATA[7:0];
        end
    end

    // Sequencer FSM with registered strobe, busy and done outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            idx      <= '0;
            busy_q   <= 1'b0;
            g_psel_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            g_psel_q <= 1'b0;
            done_q   <= 1'b0;
            if (stop_req) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_q && (len_q != '0)) begin
                            state    <= ST_WRITE;
                            idx      <= '0;
                            busy_q   <= 1'b1;
                            g_psel_q <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cnt_zero) begin
                            if (!last_entry) begin
                                idx      <= idx + 5'd1;
                                state    <= ST_WRITE;
                                g_psel_q <= 1'b1;
                            end else if (loop_q) begin
                                idx      <= '0;
                                state    <= ST_WRITE;
                                g_psel_q <= 1'b1;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign g_psel     = g_psel_q;
    assign g_pwrite   = g_psel_q;
    assign g_pwdata   = g_psel_q ? {24'h0, pattern[idx[IDX_W-1:0]]} : 32'h0;
    assign busy       = busy_q;
    assign done_pulse = done_q;

    // Config readback, combinational on PADDR
    always_comb begin
        PRDATA = '0;
        if (pat_hit) begin
            PRDATA[7:0] = pattern[pat_word[IDX_W-1:0]];
        end else begin
            case (PADDR)
                ADDR_CTRL:     PRDATA[CTRL_LOOP] = loop_q;
                ADDR_STATUS: begin
                    PRDATA[0]    = busy_q;
                    PRDATA[12:8] = idx;
                end
                ADDR_INTERVAL: PRDATA[CNT_W-1:0] = interval_q;
                ADDR_LEN:      PRDATA[4:0] = len_q;
                default:       PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Bench for gpio_pattern_seq: randomized configurations, outputs captured per
// cycle and compared to a strobe-schedule model derived from interval/length.
module tb_gpio_pattern_seq;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int MAXC  = 256;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_INTV   = 6'h08;
    localparam logic [5:0] A_LEN    = 6'h0C;
    localparam logic [5:0] A_PAT    = 6'h20;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PWRITE = 1'b0;
    logic [5:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        g_psel;
    logic        g_pwrite;
    logic [31:0] g_pwdata;
    logic        busy;
    logic        done_pulse;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  exp_pat [DEPTH];
    logic [35:0] act_v [MAXC];
    logic [35:0] exp_v [MAXC];

    always #5 PCLK = ~PCLK;

    gpio_pattern_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PSEL       (PSEL),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .g_psel     (g_psel),
        .g_pwrite   (g_pwrite),
        .g_pwdata   (g_pwdata),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PSEL = 1'b1; PWRITE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        PADDR = a; PSEL = 1'b1; PWRITE = 1'b0;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic load_pat(input int i, input logic [7:0] v);
        exp_pat[i] = v;
        apb_write(A_PAT + 6'(4 * i), {24'h0, v});
    endtask

    // Record outputs for cycles 1..ncyc after the START edge, optionally
    // injecting a CTRL write or a pattern write during a given cycle.
    task automatic capture(input int ncyc, input int stop_at, input logic [31:0] stop_d,
                           input int wr_at, input int wr_i, input logic [7:0] wr_v);
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge PCLK); #1;
            PSEL = 1'b0; PWRITE = 1'b0;
            if (n == stop_at) begin
                PADDR = A_CTRL; PWDATA = stop_d; PSEL = 1'b1; PWRITE = 1'b1;
            end
            if (n == wr_at) begin
                PADDR = A_PAT + 6'(4 * wr_i); PWDATA = {24'h0, wr_v}; PSEL = 1'b1; PWRITE = 1'b1;
            end
            @(negedge PCLK);
            act_v[n] = {busy, g_psel, g_pwrite, done_pulse, (g_psel ? g_pwdata : 32'h0)};
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PWRITE = 1'b0;
    endtask

    // Strobe k lands in cycle 1 + k*(interval+2); a non-loop run ends with
    // done in the cycle where strobe number leff would have been.
    task automatic model(input int ival, input int leff, input bit lp, input int ncyc,
                         input int stop_at, input int wr_at, input int wr_i, input logic [7:0] wr_v);
        logic [7:0] pat [DEPTH];
        int period;
        int k;
        int r;
        bit b;
        bit s;
        bit d;
        logic [7:0] v;
        period = ival + 2;
        for (int i = 0; i < DEPTH; i++) pat[i] = exp_pat[i];
        for (int n = 1; n <= ncyc; n++) begin
            b = 0; s = 0; d = 0; v = 8'h00;
            if (wr_at > 0 && n == wr_at + 1) pat[wr_i] = wr_v;
            if (leff > 0 && !(stop_at > 0 && n > stop_at)) begin
                k = (n - 1) / period;
                r = (n - 1) % period;
                if (lp || k < leff) begin
                    b = 1;
                    s = (r == 0);
                    if (s) v = pat[k % leff];
                end else if (n == 1 + leff * period) begin
                    d = 1;
                end
            end
            exp_v[n] = {b, s, s, d, 24'h0, v};
        end
        if (wr_at > 0) exp_pat[wr_i] = wr_v;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        vectors++;
        if ({busy, g_psel, g_pwrite, done_pulse, g_pwdata} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, g_psel, g_pwrite, done_pulse, g_pwdata});
        end
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apb_read((i < 4) ? 6'(4 * i) : A_PAT, rd);
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_reg%0d got=%h exp=0", i, rd);
            end
        end
        for (int i = 0; i < DEPTH; i++) exp_pat[i] = 8'h00;
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        load_pat(0, 8'hA5); load_pat(1, 8'h5A); load_pat(2, 8'hFF);
        apb_write(A_INTV, 32'd2);
        apb_write(A_LEN, 32'd3);
        apb_write(A_CTRL, 32'h1);
        capture(20, 0, 0, 0, 0, 0);
        model(2, 3, 0, 20, 0, 0, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL basic cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL basic_status got=%h exp=00000200", rd);
        end
    endtask

    task automatic test_len_zero;
        logic [31:0] rd;
        apb_write(A_LEN, 32'd0);
        apb_write(A_CTRL, 32'h1);
        capture(10, 0, 0, 0, 0, 0);
        model(0, 0, 0, 10, 0, 0, 0, 0);
        for (int n = 1; n <= 10; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL len_zero cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_read(A_STATUS, rd);
        vectors++;
        if (rd[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL len_zero_status got=%h exp busy=0", rd);
        end
    endtask

    task automatic test_loop_stop;
        logic [31:0] rd;
        int s;
        load_pat(0, 8'($urandom)); load_pat(1, 8'($urandom));
        apb_write(A_INTV, 32'd0);
        apb_write(A_LEN, 32'd2);
        apb_write(A_CTRL, 32'h5);
        s = $urandom_range(6, 15);
        capture(s + 6, s, 32'h6, 0, 0, 0);
        model(0, 2, 1, s + 6, s, 0, 0, 0);
        for (int n = 1; n <= s + 6; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL loop_stop cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_read(A_STATUS, rd);
        vectors++;
        if (rd !== {19'h0, 5'(((s - 1) / 2) % 2), 8'h00}) begin
            miscompares++;
            $display("FAIL loop_stop_status got=%h exp idx=%0d busy=0", rd, ((s - 1) / 2) % 2);
        end
        apb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_start_stop;
        logic [31:0] rd;
        int s;
        apb_write(A_LEN, 32'd3);
        apb_write(A_INTV, 32'd1);
        apb_write(A_CTRL, 32'h3);
        capture(8, 0, 0, 0, 0, 0);
        model(1, 0, 0, 8, 0, 0, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL startstop_idle cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_write(A_CTRL, 32'h1);
        s = $urandom_range(3, 10);
        capture(s + 5, s, 32'h3, 0, 0, 0);
        model(1, 3, 0, s + 5, s, 0, 0, 0);
        for (int n = 1; n <= s + 5; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL startstop_busy cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_write(A_INTV, 32'd40);
        apb_write(A_LEN, 32'd2);
        apb_write(A_CTRL, 32'h1);
        repeat (3) @(posedge PCLK);
        #1;
        apb_write(A_INTV, 32'd5);
        apb_write(A_LEN, 32'd7);
        apb_read(A_INTV, rd);
        vectors++;
        if (rd !== 32'd40) begin
            miscompares++;
            $display("FAIL busy_interval_wr got=%h exp=%h", rd, 32'd40);
        end
        apb_read(A_LEN, rd);
        vectors++;
        if (rd !== 32'd2) begin
            miscompares++;
            $display("FAIL busy_len_wr got=%h exp=%h", rd, 32'd2);
        end
        apb_read(A_STATUS, rd);
        vectors++;
        if (rd[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_status got=%h exp busy=1", rd);
        end
        apb_write(A_CTRL, 32'h2);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_len_clamp;
        logic [31:0] rd;
        int iv;
        int per;
        int wa;
        int nc;
        logic [7:0] nv;
        for (int i = 0; i < DEPTH; i++) load_pat(i, 8'($urandom));
        iv = $urandom_range(0, 3);
        per = iv + 2;
        apb_write(A_INTV, 32'(iv));
        apb_write(A_LEN, 32'd20);
        apb_write(A_CTRL, 32'h1);
        wa = $urandom_range(1, 5 * per);
        nv = ~exp_pat[5];
        nc = 8 * per + 4;
        capture(nc, 0, 0, wa, 5, nv);
        model(iv, 8, 0, nc, 0, wa, 5, nv);
        for (int n = 1; n <= nc; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL len_clamp cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        apb_read(A_LEN, rd);
        vectors++;
        if (rd !== 32'd20) begin
            miscompares++;
            $display("FAIL len_clamp_len got=%h exp=%h", rd, 32'd20);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        for (int i = 0; i < 3; i++) load_pat(i, 8'($urandom));
        apb_write(A_INTV, 32'd10);
        apb_write(A_LEN, 32'd3);
        apb_write(A_CTRL, 32'h5);
        capture(6, 0, 0, 0, 0, 0);
        model(10, 3, 1, 6, 0, 0, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL reset_mid_run cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
        #2 PRESETn = 1'b0;
        #1;
        vectors++;
        if ({busy, g_psel, done_pulse} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got=%b exp=000", {busy, g_psel, done_pulse});
        end
        for (int i = 0; i < 7; i++) begin
            apb_read((i < 4) ? 6'(4 * i) : A_PAT + 6'(4 * (i - 4)), rd);
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_mid_reg%0d got=%h exp=0", i, rd);
            end
        end
        for (int i = 0; i < DEPTH; i++) exp_pat[i] = 8'h00;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) load_pat(i, 8'($urandom));
        apb_write(A_INTV, 32'd1);
        apb_write(A_LEN, 32'd3);
        apb_write(A_CTRL, 32'h1);
        capture(12, 0, 0, 0, 0, 0);
        model(1, 3, 0, 12, 0, 0, 0, 0);
        for (int n = 1; n <= 12; n++) begin
            vectors++;
            if (act_v[n] !== exp_v[n]) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc%0d got=%h exp=%h", n, act_v[n], exp_v[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int iv;
        int ln;
        int le;
        int s;
        int nc;
        bit lp;
        for (int t = 0; t < 4; t++) begin
            iv = $urandom_range(0, 4);
            ln = $urandom_range(1, 10);
            le = (ln > DEPTH) ? DEPTH : ln;
            lp = 1'($urandom_range(0, 1));
            for (int i = 0; i < DEPTH; i++) load_pat(i, 8'($urandom));
            apb_write(A_INTV, 32'(iv));
            apb_write(A_LEN, 32'(ln));
            apb_write(A_CTRL, {29'h0, lp, 2'b01});
            s = lp ? $urandom_range(5, 30) : 0;
            nc = lp ? s + 4 : le * (iv + 2) + 3;
            capture(nc, s, {29'h0, lp, 2'b10}, 0, 0, 0);
            model(iv, le, lp, nc, s, 0, 0, 0);
            for (int n = 1; n <= nc; n++) begin
                vectors++;
                if (act_v[n] !== exp_v[n]) begin
                    miscompares++;
                    $display("FAIL b2b%0d cyc%0d got=%h exp=%h", t, n, act_v[n], exp_v[n]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len_zero;
        test_loop_stop;
        test_start_stop;
        test_len_clamp;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
